rv_instr_stim_gen: RTL and testbench

Synthesizable, parametrised RV32I instruction stimulus generator for the Fibonacci microprocessor bench and for FPGA self-test. It produces a stream of ADD, ADDI, BEQ and JAL instructions from a 32-bit LFSR, using a programmable weighted mix. Instructions are delivered over a valid/ready handshake to the fetch or instruction-memory loader. It supports seed reload, a bounded or unbounded instruction count, and alignment-correct branch and jump offsets.

---
 rtl/rv_instr_stim_gen.sv | 142 ++++++++++++++
 tb/tb_rv_instr_stim_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_instr_stim_gen.sv
// rv_instr_stim_gen: RV32I instruction stimulus generator.
// Emits ADD/ADDI/BEQ/JAL instructions decoded from a 32-bit Galois LFSR with a
// programmable weighted mix, over a valid/ready handshake.
// Ports:
//   clk_i, arst_i        clock (rising edge), asynchronous active-high reset
//   start_i              begin a run (sampled in IDLE only)
//   seed_load_i, seed_i  load LFSR seed in IDLE (seed 0 loads 1); wins over start
//   num_instr_i          instructions per run, latched at start; 0 = unbounded
//   instr_valid_o/ready_i handshake; instr_o/instr_type_o decoded from the LFSR
//   busy_o               high while generating
//   done_o               one-cycle pulse after the last instruction of a bounded run
module rv_instr_stim_gen #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DIR_WIDTH  = 5,
  parameter int          ADD_W      = 4,
  parameter int          ADDI_W     = 4,
  parameter int          BEQ_W      = 4,
  parameter int          JAL_W      = 4,
  parameter int          OFF_W      = 8,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] SEED       = 32'hACE1_2025,
  parameter bit          ALLOW_X0   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  start_i,
  input  logic                  seed_load_i,
  input  logic [31:0]           seed_i,
  input  logic [CNT_W-1:0]      num_instr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [1:0]            instr_type_o,
  output logic                  busy_o,
  output logic                  done_o
);

  if (ADD_W + ADDI_W + BEQ_W + JAL_W != 16) begin : g_bad_weights
    $error("instruction weights must sum to 16");
  end

  localparam logic [4:0]  T_ADD  = 5'(ADD_W);
  localparam logic [4:0]  T_ADDI = 5'(ADD_W + ADDI_W);
  localparam logic [4:0]  T_BEQ  = 5'(ADD_W + ADDI_W + BEQ_W);
  localparam logic [4:0]  RMASK  = 5'((32'd1 << DIR_WIDTH) - 32'd1);
  localparam logic [31:0] POLY   = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  state_t             state_q;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, bound_q;
  logic               valid_q, busy_q, done_q;
  logic               hs;

  assign hs     = valid_q & instr_ready_i;
  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
  assign cnt_d  = cnt_q + CNT_W'(1);

  // ---------------- field decode (combinational from LFSR) ----------------
  logic [4:0]       r5, rd_raw, rd, rs1, rs2;
  logic [OFF_W-1:0] off_raw;
  logic [20:0]      off;
  logic [1:0]       typ;
  logic [31:0]      ins;

  assign r5      = {1'b0, lfsr_q[3:0]};
  assign rd_raw  = lfsr_q[8:4] & RMASK;
  assign rd      = (!ALLOW_X0 && rd_raw == 5'd0) ? 5'd1 : rd_raw;
  assign rs1     = lfsr_q[13:9] & RMASK;
  assign rs2     = lfsr_q[18:14] & RMASK;
  // Word-aligned offset: low two bits always zero, then sign-extended to 21 bits.
  assign off_raw = {lfsr_q[OFF_W+16:19], 2'b00};
  assign off     = {{(21-OFF_W){off_raw[OFF_W-1]}}, off_raw};

  always_comb begin
    typ = 2'd3;
    ins = '0;
    if      (r5 < T_ADD)  typ = 2'd0;
    else if (r5 < T_ADDI) typ = 2'd1;
    else if (r5 < T_BEQ)  typ = 2'd2;
    case (typ)
      2'd0:    ins = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
      2'd1:    ins = {lfsr_q[30:19], rs1, 3'b000, rd, 7'b0010011};
      2'd2:    ins = {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
      default: ins = {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endcase
  end

  assign instr_o       = ins;
  assign instr_type_o  = typ;
  assign instr_valid_o = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      bound_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (seed_load_i) begin
            lfsr_q <= (seed_i == 32'h0) ? 32'h1 : seed_i;
          end else if (start_i) begin
            bound_q <= num_instr_i;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_GEN;
          end
        end
        S_GEN: begin
          if (hs) begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            // Bound 0 never matches, so unbounded runs wrap the counter freely.
            if (bound_q != '0 && cnt_d == bound_q) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_instr_stim_gen.sv
// Scoreboard bench for rv_instr_stim_gen: the stimulus process pushes expected
// instructions computed by a reference model; a negedge monitor pops and
// compares on every accepted handshake and checks hold/done behaviour.
module tb_rv_instr_stim_gen;
  localparam int          DW   = 3;
  localparam int          OW   = 8;
  localparam int          CW   = 4;
  localparam logic [31:0] SEED = 32'hACE1_2025;
  localparam logic [31:0] RM   = (32'd1 << DW) - 32'd1;

  logic          clk_i = 1'b0;
  logic          arst_i, start_i, seed_load_i, instr_ready_i;
  logic [31:0]   seed_i;
  logic [CW-1:0] num_instr_i;
  logic          instr_valid_o, busy_o, done_o;
  logic [31:0]   instr_o;
  logic [1:0]    instr_type_o;

  rv_instr_stim_gen #(
    .DATA_WIDTH(32), .DIR_WIDTH(DW), .ADD_W(4), .ADDI_W(4), .BEQ_W(4), .JAL_W(4),
    .OFF_W(OW), .CNT_W(CW), .SEED(SEED), .ALLOW_X0(1'b0)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .start_i(start_i), .seed_load_i(seed_load_i),
    .seed_i(seed_i), .num_instr_i(num_instr_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_o(instr_o), .instr_type_o(instr_type_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [31:0] ins; logic [1:0] typ; } exp_t;
  exp_t q[$];
  int   pass_n = 0, tot_n = 0, hs_n = 0, ready_mode = 1;
  logic bounded = 1'b0;
  logic [31:0] m_lfsr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tot_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference: decode the LFSR word arithmetically into an encoded instruction.
  function automatic exp_t model(input logic [31:0] s);
    logic [31:0] r, rd, rs1, rs2, imm12, o, u;
    int off;
    exp_t e;
    r     = s & 32'hF;
    rd    = (s >> 4) & 32'h1F & RM;
    rs1   = (s >> 9) & 32'h1F & RM;
    rs2   = (s >> 14) & 32'h1F & RM;
    if (rd == 0) rd = 1;
    imm12 = (s >> 19) & 32'hFFF;
    o     = (s >> 19) & ((32'd1 << (OW - 2)) - 1);
    off   = int'(o) * 4;
    if (off >= (1 << (OW - 1))) off -= (1 << OW);
    u     = off;
    if (r < 4)       e.typ = 2'd0;
    else if (r < 8)  e.typ = 2'd1;
    else if (r < 12) e.typ = 2'd2;
    else             e.typ = 2'd3;
    case (e.typ)
      2'd0: e.ins = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
      2'd1: e.ins = (imm12 << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
      2'd2: e.ins = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) |
                    (rs1 << 15) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      default: e.ins = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) |
                       (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12) | (rd << 7) | 32'h6F;
    endcase
    return e;
  endfunction

  // Ready driver, updated slightly after the stimulus edge so mode changes take effect cleanly.
  initial begin
    instr_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #2;
      case (ready_mode)
        0:       instr_ready_i = 1'b0;
        1:       instr_ready_i = 1'b1;
        default: instr_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor
  exp_t e;
  logic hold_pend = 1'b0, done_exp = 1'b0;
  logic [31:0] hold_ins, f;
  logic signed [20:0] jimm;
  logic signed [12:0] bimm;
  int iv;
  initial forever begin
    @(negedge clk_i);
    if (arst_i) begin
      hold_pend = 1'b0; done_exp = 1'b0;
    end else begin
      if (done_exp || done_o) chk("done_pulse", done_o, done_exp);
      done_exp = 1'b0;
      if (hold_pend) begin
        chk("hold_valid", instr_valid_o, 1);
        chk("hold_instr", instr_o, hold_ins);
      end
      hold_pend = 1'b0;
      if (instr_valid_o && instr_ready_i) begin
        hs_n++;
        if (q.size() == 0) chk("extra_handshake", 1, 0);
        else begin
          e = q.pop_front();
          chk("instr", instr_o, e.ins);
          chk("instr_type", instr_type_o, e.typ);
          chk("busy_in_gen", busy_o, 1);
          f = instr_o;
          if (e.typ != 2'd2) chk("rd_range", (f[11:7] < 8) && (f[11:7] != 0), 1);
          if (e.typ != 2'd3) chk("rs1_range", f[19:15] < 8, 1);
          if (e.typ == 2'd0 || e.typ == 2'd2) chk("rs2_range", f[24:20] < 8, 1);
          if (e.typ == 2'd3) begin
            jimm = {f[31], f[19:12], f[20], f[30:21], 1'b0};
            iv = int'(jimm);
            chk("jal_imm", (iv >= -128) && (iv <= 124) && (iv % 4 == 0), 1);
          end
          if (e.typ == 2'd2) begin
            bimm = {f[31], f[7], f[30:25], f[11:8], 1'b0};
            iv = int'(bimm);
            chk("beq_imm", (iv >= -128) && (iv <= 124) && (iv % 4 == 0), 1);
          end
          if (bounded && q.size() == 0) done_exp = 1'b1;
        end
      end else if (instr_valid_o) begin
        hold_pend = 1'b1; hold_ins = instr_o;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic start_run(input int cnt, input int nexp);
    for (int i = 0; i < nexp; i++) begin
      q.push_back(model(m_lfsr));
      m_lfsr = step(m_lfsr);
    end
    bounded = (cnt != 0);
    num_instr_i = CW'(cnt);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("valid_after_start", instr_valid_o, 1);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done_o) begin cyc = i; break; end
    end
    if (cyc < 0) chk("done_timeout", 0, 1);
    else begin
      chk("valid_at_done", instr_valid_o, 0);
      chk("busy_at_done", busy_o, 0);
      chk("queue_drained", q.size(), 0);
    end
    tick();
    chk("done_one_cycle", done_o, 0);
  endtask

  int cyc, h0, n;
  initial begin
    arst_i = 1'b1; start_i = 1'b0; seed_load_i = 1'b0; seed_i = '0; num_instr_i = '0;
    m_lfsr = SEED;
    tick(); tick();
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    arst_i = 1'b0;
    tick();

    // Bounded run at full throughput: done exactly 4 cycles after valid rises.
    ready_mode = 1;
    start_run(4, 4);
    wait_done(50, cyc);
    chk("run4_latency", cyc, 4);

    // Backpressure mid-run; start/seed_load in GEN must be ignored.
    start_run(12, 12);
    tick(); tick(); tick();
    ready_mode = 0; seed_load_i = 1'b1; seed_i = $urandom; start_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    seed_load_i = 1'b0; start_i = 1'b0; ready_mode = 1;
    wait_done(60, cyc);

    // Random-ready runs of random length.
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 15);
      start_run(n, n);
      wait_done(400, cyc);
    end
    ready_mode = 1;

    // Seed 0 loads as 1.
    seed_i = 32'h0; seed_load_i = 1'b1; tick(); seed_load_i = 1'b0;
    m_lfsr = 32'h1;
    start_run(5, 5);
    wait_done(50, cyc);

    // seed_load beats start in the same cycle; same seed twice gives the same stream.
    for (int k = 0; k < 2; k++) begin
      seed_i = 32'h1234_5678; seed_load_i = 1'b1; start_i = 1'b1; num_instr_i = 4'd3;
      tick();
      seed_load_i = 1'b0; start_i = 1'b0;
      chk("seed_load_priority", instr_valid_o, 0);
      m_lfsr = 32'h1234_5678;
      start_run(6, 6);
      wait_done(50, cyc);
    end

    // Unbounded run must survive counter wrap; only reset ends it.
    h0 = hs_n;
    start_run(0, 60);
    for (int i = 0; i < 40; i++) tick();
    chk("unbounded_busy", busy_o, 1);
    chk("unbounded_count", (hs_n - h0) > (1 << CW), 1);
    arst_i = 1'b1;
    tick();
    chk("arst_unb_valid", instr_valid_o, 0);
    q.delete(); bounded = 1'b0; m_lfsr = SEED;
    arst_i = 1'b0;
    tick();

    // Reset during the 3rd beat of a 10-instruction run.
    start_run(10, 10);
    tick(); tick();
    #2 arst_i = 1'b1;
    @(negedge clk_i);
    chk("arst_valid", instr_valid_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    tick();
    q.delete(); bounded = 1'b0; m_lfsr = SEED;
    arst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); chk("no_done_after_arst", done_o, 0); end
    start_run(5, 5);
    wait_done(50, cyc);
    chk("restart_latency", cyc, 5);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
